commit_unit: RTL
================

Name: commit_unit

Overview:
- Retirement stage directly downstream of the reorder buffer. Consumes one retiring entry per cycle.
- Three jobs:
  - Drive architectural register-file writeback, including the ROB tag used for rename clearing.
  - Release committed stores to the load/store buffer.
  - On a redirecting instruction, own the global flush: a multi-cycle clear_branch pulse plus a one-shot PC redirect to fetch.

Parameters:
- INSTR_ID_W, 6, instruction-id width.
- ROB_IDX_W, 4, ROB index width.
- LSB_IDX_W, 4, LSB index width.
- WORD_W, 32, data/address width.
- STORE_ID_LO, 8, lowest store instr id (SB).
- STORE_ID_HI, 10, highest store instr id (SW).
- BRANCH_ID_LO, 22, lowest conditional-branch instr id.
- BRANCH_ID_HI, 27, highest conditional-branch instr id.
- FLUSH_CYCLES, 2, clear_branch_out high time in cycles; legal range 1..15.

Ports:
- clk_in, in, 1, clock.
- rst_in, in, 1, reset, synchronous, active-low.
- rdy_in, in, 1, global ready; 0 freezes the block.
- commit_en_in, in, 1, ROB head retiring this cycle.
- instr_id_in, in, INSTR_ID_W, retiring instruction id.
- rd_in, in, 5, destination register.
- rob_pos_in, in, ROB_IDX_W, ROB slot of the retiring instruction.
- lsb_pos_in, in, LSB_IDX_W, LSB slot (stores).
- res_in, in, WORD_W, result value.
- jump_en_in, in, 1, redirect required.
- jump_a_in, in, WORD_W, redirect target.
- reg_wr_en_out, out, 1, register-file write strobe.
- reg_wr_idx_out, out, 5, register-file write index.
- reg_wr_data_out, out, WORD_W, register-file write data.
- reg_wr_rob_pos_out, out, ROB_IDX_W, tag to clear in the rename table if it still matches.
- lsb_commit_en_out, out, 1, store commit strobe.
- lsb_commit_pos_out, out, LSB_IDX_W, store slot being committed.
- clear_branch_out, out, 1, global flush to ROB/RS/LSB/issue.
- redirect_en_out, out, 1, fetch redirect strobe.
- redirect_pc_out, out, WORD_W, fetch redirect target.
- flushing_out, out, 1, FSM is in FLUSH.
- instret_out, out, 64, retired-instruction count (feature).
- mispredict_cnt_out, out, 32, redirect count (feature).

Behaviour:
- Reset: rst_in==0 at a rising edge.
  - All outputs and counters go to 0; FSM goes to RUN.
  - Reset overrides rdy_in and aborts any flush in progress.
- Latency: every output is registered, one cycle after the accepted input.
  - reg_wr_en_out, lsb_commit_en_out and redirect_en_out are single-cycle pulses that default to 0.
- Acceptance: an input is accepted when rst_in==1, rdy_in==1, FSM==RUN and commit_en_in==1.
- Classification of an accepted input:
  - is_store = STORE_ID_LO <= instr_id_in <= STORE_ID_HI.
  - is_branch = BRANCH_ID_LO <= instr_id_in <= BRANCH_ID_HI.
- Register writeback:
  - Condition: !is_store && !is_branch && rd_in!=0.
  - Action: reg_wr_en_out=1, with idx/data/rob_pos registered from rd_in/res_in/rob_pos_in.
  - rd_in==0 produces no write, but still retires.
- Store commit:
  - Condition: is_store.
  - Action: lsb_commit_en_out=1, lsb_commit_pos_out=lsb_pos_in.
- Redirect, on jump_en_in==1:
  - redirect_en_out=1 and redirect_pc_out=jump_a_in.
  - clear_branch_out=1; FSM goes to FLUSH with cnt=FLUSH_CYCLES-1.
  - The instruction's own writeback/store commit is still performed in the same cycle (JAL/JALR link write is not lost).
- FSM:
  - RUN: as above. FLUSH_CYCLES==1 returns to RUN on the next edge.
  - FLUSH: commit_en_in ignored; clear_branch_out held 1; flushing_out=1.
    - cnt!=0: decrement.
    - cnt==0: clear_branch_out=0 and FSM goes to RUN.
  - clear_branch_out is high exactly FLUSH_CYCLES consecutive ready cycles.
- rdy_in==0:
  - FSM, counter and clear_branch_out/flushing_out hold.
  - Pulse outputs go to 0; no input is accepted.
  - Data outputs hold their last value.
- Redirect arriving on the first RUN cycle after a flush is accepted normally, so back-to-back flushes are legal.
- redirect_pc_out and the reg_wr data/idx outputs hold their value when their strobes are low.

Optional Feature:
- Macro: COMMIT_PERF_EN.
- Defined:
  - instret_out increments by 1 per accepted input (wraps at 2^64).
  - mispredict_cnt_out increments per accepted input with jump_en_in=1 (wraps at 2^32).
  - Both counters are frozen when rdy_in==0 and cleared on reset.
- Undefined: both outputs are tied to constant 0 and no counter registers exist.

Test Plan:
- Writeback and rd=x0:
  - Reset low 2 cycles, then commit ADD: rd=5, res=0x1234, rob_pos=3 -> next cycle reg_wr_en=1, idx=5, data=0x1234, rob_pos=3; all other strobes 0.
  - Then rd=0 -> reg_wr_en=0; instret increments (COMMIT_PERF_EN).
- Store commit: commit instr_id=9, lsb_pos=7, rd=4 -> lsb_commit_en=1 with pos=7; reg_wr_en=0.
- Redirect with link write, FLUSH_CYCLES=2:
  - Commit JAL: rd=1, res=0x104, jump_en=1, jump_a=0x200 -> next cycle redirect_en=1, pc=0x200, reg_wr idx=1 data=0x104.
  - clear_branch high exactly 2 cycles.
  - commit_en held 1 during FLUSH produces no strobes.
- rdy stall mid-flush: drop rdy_in for 3 cycles in FLUSH -> clear_branch stays high, total high time = 2 ready cycles + 3 stalled.
- Reset mid-flush: rst_in=0 in FLUSH -> next cycle clear_branch=0, flushing=0, counters 0; next commit accepted normally.
- Branch not taken plus back-to-back redirects:
  - Branch id 22, jump_en=0 -> no write, no flush.
  - Redirect on the first RUN cycle after a flush -> new flush begins; mispredict_cnt=2.

Source files
------------

// File: rtl/commit_unit.sv
// Retirement stage after the ROB: register writeback, store release, and flush/redirect ownership.
// Optional retire/mispredict counters are built when COMMIT_PERF_EN is defined.
module commit_unit #(
  parameter int unsigned INSTR_ID_W   = 6,
  parameter int unsigned ROB_IDX_W    = 4,
  parameter int unsigned LSB_IDX_W    = 4,
  parameter int unsigned WORD_W       = 32,
  parameter int unsigned STORE_ID_LO  = 8,
  parameter int unsigned STORE_ID_HI  = 10,
  parameter int unsigned BRANCH_ID_LO = 22,
  parameter int unsigned BRANCH_ID_HI = 27,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  commit_en_in,
  input  logic [INSTR_ID_W-1:0] instr_id_in,
  input  logic [4:0]            rd_in,
  input  logic [ROB_IDX_W-1:0]  rob_pos_in,
  input  logic [LSB_IDX_W-1:0]  lsb_pos_in,
  input  logic [WORD_W-1:0]     res_in,
  input  logic                  jump_en_in,
  input  logic [WORD_W-1:0]     jump_a_in,
  output logic                  reg_wr_en_out,
  output logic [4:0]            reg_wr_idx_out,
  output logic [WORD_W-1:0]     reg_wr_data_out,
  output logic [ROB_IDX_W-1:0]  reg_wr_rob_pos_out,
  output logic                  lsb_commit_en_out,
  output logic [LSB_IDX_W-1:0]  lsb_commit_pos_out,
  output logic                  clear_branch_out,
  output logic                  redirect_en_out,
  output logic [WORD_W-1:0]     redirect_pc_out,
  output logic                  flushing_out,
  output logic [63:0]           instret_out,
  output logic [31:0]           mispredict_cnt_out
);

  localparam logic StRun   = 1'b0;
  localparam logic StFlush = 1'b1;

  localparam logic [INSTR_ID_W-1:0] StoreLo  = INSTR_ID_W'(STORE_ID_LO);
  localparam logic [INSTR_ID_W-1:0] StoreHi  = INSTR_ID_W'(STORE_ID_HI);
  localparam logic [INSTR_ID_W-1:0] BranchLo = INSTR_ID_W'(BRANCH_ID_LO);
  localparam logic [INSTR_ID_W-1:0] BranchHi = INSTR_ID_W'(BRANCH_ID_HI);
  localparam logic [3:0]            FlushInit = 4'(FLUSH_CYCLES - 1);

  logic                 state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 wr_en_q, wr_en_d;
  logic [4:0]           wr_idx_q, wr_idx_d;
  logic [WORD_W-1:0]    wr_data_q, wr_data_d;
  logic [ROB_IDX_W-1:0] wr_rob_q, wr_rob_d;
  logic                 lsb_en_q, lsb_en_d;
  logic [LSB_IDX_W-1:0] lsb_pos_q, lsb_pos_d;
  logic                 redir_en_q, redir_en_d;
  logic [WORD_W-1:0]    redir_pc_q, redir_pc_d;

  logic is_store, is_branch;
  assign is_store  = (instr_id_in >= StoreLo) && (instr_id_in <= StoreHi);
  assign is_branch = (instr_id_in >= BranchLo) && (instr_id_in <= BranchHi);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_en_d    = 1'b0;
    wr_idx_d   = wr_idx_q;
    wr_data_d  = wr_data_q;
    wr_rob_d   = wr_rob_q;
    lsb_en_d   = 1'b0;
    lsb_pos_d  = lsb_pos_q;
    redir_en_d = 1'b0;
    redir_pc_d = redir_pc_q;
    if (rdy_in) begin
      if (state_q == StRun) begin
        if (commit_en_in) begin
          if (!is_store && !is_branch && (rd_in != 5'd0)) begin
            wr_en_d   = 1'b1;
            wr_idx_d  = rd_in;
            wr_data_d = res_in;
            wr_rob_d  = rob_pos_in;
          end
          if (is_store) begin
            lsb_en_d  = 1'b1;
            lsb_pos_d = lsb_pos_in;
          end
          // Link writes / store releases above still happen alongside the redirect.
          if (jump_en_in) begin
            redir_en_d = 1'b1;
            redir_pc_d = jump_a_in;
            state_d    = StFlush;
            cnt_d      = FlushInit;
          end
        end
      end else begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = StRun;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q    <= StRun;
      cnt_q      <= 4'd0;
      wr_en_q    <= 1'b0;
      wr_idx_q   <= 5'd0;
      wr_data_q  <= '0;
      wr_rob_q   <= '0;
      lsb_en_q   <= 1'b0;
      lsb_pos_q  <= '0;
      redir_en_q <= 1'b0;
      redir_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_en_q    <= wr_en_d;
      wr_idx_q   <= wr_idx_d;
      wr_data_q  <= wr_data_d;
      wr_rob_q   <= wr_rob_d;
      lsb_en_q   <= lsb_en_d;
      lsb_pos_q  <= lsb_pos_d;
      redir_en_q <= redir_en_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  assign reg_wr_en_out      = wr_en_q;
  assign reg_wr_idx_out     = wr_idx_q;
  assign reg_wr_data_out    = wr_data_q;
  assign reg_wr_rob_pos_out = wr_rob_q;
  assign lsb_commit_en_out  = lsb_en_q;
  assign lsb_commit_pos_out = lsb_pos_q;
  assign redirect_en_out    = redir_en_q;
  assign redirect_pc_out    = redir_pc_q;
  // The flush window is exactly the time spent in FLUSH.
  assign clear_branch_out   = (state_q == StFlush);
  assign flushing_out       = (state_q == StFlush);

`ifdef COMMIT_PERF_EN
  logic        accept;
  logic [63:0] instret_q;
  logic [31:0] mispredict_q;

  assign accept = rdy_in && (state_q == StRun) && commit_en_in;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      instret_q    <= 64'd0;
      mispredict_q <= 32'd0;
    end else if (accept) begin
      instret_q <= instret_q + 64'd1;
      if (jump_en_in) mispredict_q <= mispredict_q + 32'd1;
    end
  end

  assign instret_out        = instret_q;
  assign mispredict_cnt_out = mispredict_q;
`else
  assign instret_out        = 64'd0;
  assign mispredict_cnt_out = 32'd0;
`endif

endmodule
